// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS front end.
//   fetch_state_e : fetch-unit sequencer states
//   NOP_INSTR     : instruction word written into IF/ID on a flush
//   PC_INC        : sequential PC step in bytes
//   OP_*          : primary opcode values seen on instr[31:26]
//   jump_addr()   : J-format target from PC region and instr_index
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic [31:0] jump_addr(input logic [3:0]  region,
                                              input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC selection for the fetch unit.
// Priority: reset -> redirect (branch over jump) -> sequential -> hold.
// Ports:
//   reset_ni        active-low reset (selects RESET_PC)
//   branch_taken_i  resolved taken branch, target branch_target_i
//   jump_i          jump in IF/ID, target from pc_region_i + jump_index_i
//   advance_i       PC steps by PC_INC this cycle
//   pc_i            current PC
//   redirect_o      a branch or jump is redirecting fetch
//   pc_inc_o        pc_i + PC_INC (mod 2^32)
//   pc_next_o       PC for the next cycle
module next_pc_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        reset_ni,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic [3:0]  pc_region_i,
    input  logic        advance_i,
    input  logic [31:0] pc_i,
    output logic        redirect_o,
    output logic [31:0] pc_inc_o,
    output logic [31:0] pc_next_o
);

    logic [31:0] target;

    always_comb begin
        redirect_o = branch_taken_i | jump_i;
        target     = branch_taken_i ? branch_target_i
                                    : jump_addr(pc_region_i, jump_index_i);
        pc_inc_o   = pc_i + PC_INC;

        if (!reset_ni)
            pc_next_o = RESET_PC;
        else if (redirect_o)
            pc_next_o = target;
        else if (advance_i)
            pc_next_o = pc_inc_o;
        else
            pc_next_o = pc_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register.
// Optional feature: define BRANCH_DELAY_SLOT_EN to keep the IF/ID
// instruction live across a redirect instead of flushing it.
// Ports:
//   clk, reset (sync, active-low)
//   stall                 hold IF/ID and PC
//   branch_taken/target   taken branch redirect (wins over jump)
//   jump/jump_index       jump redirect for the instruction in IF/ID
//   imem_req/addr         instruction memory request
//   imem_rdata/valid      instruction memory response
//   instr/opcode/pc_plus4/if_valid  IF/ID outputs
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_plus4,
    output logic        if_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  disc_addr_q, disc_addr_d;
    logic         advance, flush, redirect;
    logic [31:0]  pc_inc;

    next_pc_sel #(.RESET_PC(RESET_PC)) u_next_pc (
        .reset_ni        (reset),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_index_i    (jump_index),
        .pc_region_i     (pc_plus4_q[31:28]),
        .advance_i       (advance),
        .pc_i            (pc_q),
        .redirect_o      (redirect),
        .pc_inc_o        (pc_inc),
        .pc_next_o       (pc_d)
    );

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
        if (!reset) begin
            state_q     <= ST_IDLE;
            instr_q     <= NOP_INSTR;
            pc_plus4_q  <= '0;
            if_valid_q  <= 1'b0;
            buf_q       <= '0;
            disc_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            if_valid_q  <= if_valid_d;
            buf_q       <= buf_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_plus4_d  = pc_plus4_q;
        if_valid_d  = if_valid_q;
        buf_d       = buf_q;
        disc_addr_d = disc_addr_q;
        advance     = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (redirect) begin
                    // The outstanding word belongs to the old path: drop it
                    // now if it arrived, else wait it out at the old address.
                    flush = 1'b1;
                    if (!imem_valid) begin
                        disc_addr_d = pc_q;
                        state_d     = ST_DISCARD;
                    end
                end else if (imem_valid) begin
                    if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        instr_d    = imem_rdata;
                        pc_plus4_d = pc_inc;
                        if_valid_d = 1'b1;
                        advance    = 1'b1;
                    end
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    flush   = 1'b1;
                    buf_d   = '0;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    instr_d    = buf_q;
                    pc_plus4_d = pc_inc;
                    if_valid_d = 1'b1;
                    advance    = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // PC already holds the target; only the stale reply is awaited.
                if (redirect)
                    flush = 1'b1;
                else if (!stall)
                    if_valid_d = 1'b0;
                if (imem_valid)
                    state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef BRANCH_DELAY_SLOT_EN
        // Delay slot: the instruction in IF/ID stays live across a redirect.
`else
        if (flush) begin
            if_valid_d = 1'b0;
            instr_d    = NOP_INSTR;
        end
`endif
    end

    assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign imem_addr = (state_q == ST_DISCARD) ? disc_addr_q : pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[31:26];
    assign pc_plus4  = pc_plus4_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// dut  : RESET_PC = 0, main functional sequence.
// dut2 : RESET_PC = 32'hFFFF_FFFC, wrap and reset-during-DISCARD.
// Memory word for address a is a ^ 32'h5A00_0000.
module tb_fetch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic DS = 1'b1;
`else
    localparam logic DS = 1'b0;
`endif

    logic        clk = 1'b0;
    int unsigned tests = 0;
    int unsigned failed = 0;

    logic        reset, stall, branch_taken, jump, zw, man_valid;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic        imem_req, imem_valid, if_valid;
    logic [31:0] imem_addr, imem_rdata, instr, pc_plus4;
    logic [5:0]  opcode;

    logic        reset2, stall2, branch_taken2, jump2, zw2, man_valid2;
    logic [31:0] branch_target2;
    logic [25:0] jump_index2;
    logic        imem_req2, imem_valid2, if_valid2;
    logic [31:0] imem_addr2, imem_rdata2, instr2, pc_plus42;
    logic [5:0]  opcode2;

    always #5 clk = ~clk;

    assign imem_valid  = zw  ? imem_req  : man_valid;
    assign imem_rdata  = imem_addr ^ 32'h5A00_0000;
    assign imem_valid2 = zw2 ? imem_req2 : man_valid2;
    assign imem_rdata2 = imem_addr2 ^ 32'h5A00_0000;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instr(instr), .opcode(opcode), .pc_plus4(pc_plus4),
        .if_valid(if_valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .stall(stall2),
        .branch_taken(branch_taken2), .branch_target(branch_target2),
        .jump(jump2), .jump_index(jump_index2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_valid(imem_valid2),
        .instr(instr2), .opcode(opcode2), .pc_plus4(pc_plus42),
        .if_valid(if_valid2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 0; stall = 0; branch_taken = 0; branch_target = '0;
        jump = 0; jump_index = '0; zw = 0; man_valid = 0;
        reset2 = 0; stall2 = 0; branch_taken2 = 0; branch_target2 = '0;
        jump2 = 0; jump_index2 = '0; zw2 = 0; man_valid2 = 0;

        // Reset state
        tick(); tick();
        chk("rst_instr", instr, 32'h0);
        chk("rst_pp4", pc_plus4, 32'h0);
        chk("rst_ifv", {31'b0, if_valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_opc", {26'b0, opcode}, 32'h0);

        // Zero-wait sequential fetch
        reset = 1; zw = 1;
        tick();
        chk("seq0_req", {31'b0, imem_req}, 32'h1);
        chk("seq0_addr", imem_addr, 32'h0);
        chk("seq0_ifv", {31'b0, if_valid}, 32'h0);
        tick();
        chk("seq1_addr", imem_addr, 32'h4);
        chk("seq1_ifv", {31'b0, if_valid}, 32'h1);
        chk("seq1_instr", instr, 32'h5A00_0000);
        chk("seq1_pp4", pc_plus4, 32'h4);
        chk("seq1_opc", {26'b0, opcode}, 32'h16);
        tick();
        chk("seq2_addr", imem_addr, 32'h8);
        chk("seq2_instr", instr, 32'h5A00_0004);

        // Stall for two cycles while word 0x8 returns
        stall = 1;
        tick();
        chk("stl1_req", {31'b0, imem_req}, 32'h0);
        chk("stl1_instr", instr, 32'h5A00_0004);
        chk("stl1_ifv", {31'b0, if_valid}, 32'h1);
        tick();
        chk("stl2_req", {31'b0, imem_req}, 32'h0);
        chk("stl2_instr", instr, 32'h5A00_0004);
        stall = 0;
        tick();
        chk("rel_instr", instr, 32'h5A00_0008);
        chk("rel_pp4", pc_plus4, 32'hC);
        chk("rel_addr", imem_addr, 32'hC);
        chk("rel_req", {31'b0, imem_req}, 32'h1);
        tick();
        chk("pre_dly_addr", imem_addr, 32'h10);

        // Memory response delayed by 3 cycles at 0x10
        zw = 0; man_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dly_ifv", {31'b0, if_valid}, 32'h0);
            chk("dly_addr", imem_addr, 32'h10);
        end
        man_valid = 1;
        tick();
        chk("dly_instr", instr, 32'h5A00_0010);
        chk("dly_pp4", pc_plus4, 32'h14);
        chk("dly_ifv1", {31'b0, if_valid}, 32'h1);
        chk("dly_next", imem_addr, 32'h14);
        man_valid = 0; zw = 1;
        tick(); tick(); tick();
        chk("pre_br_addr", imem_addr, 32'h20);
        chk("pre_br_instr", instr, 32'h5A00_001C);

        // Branch while the 0x20 request is pending
        zw = 0; branch_taken = 1; branch_target = 32'h100;
        tick();
        branch_taken = 0;
        chk("dis_req", {31'b0, imem_req}, 32'h1);
        chk("dis_addr", imem_addr, 32'h20);
        chk("dis_ifv", {31'b0, if_valid}, {31'b0, DS});
        chk("dis_instr", instr, DS ? 32'h5A00_001C : 32'h0);
        tick();
        chk("dis2_addr", imem_addr, 32'h20);
        man_valid = 1;
        tick();
        chk("br_addr", imem_addr, 32'h100);
        chk("br_ifv", {31'b0, if_valid}, 32'h0);
        chk("br_instr", instr, DS ? 32'h5A00_001C : 32'h0);

        // Branch coincident with the returned word
        branch_taken = 1; branch_target = 32'h1000_0004;
        tick();
        chk("co_addr", imem_addr, 32'h1000_0004);
        chk("co_ifv", {31'b0, if_valid}, 32'h0);
        branch_taken = 0; man_valid = 0; zw = 1;
        tick();
        chk("j_pp4", pc_plus4, 32'h1000_0008);
        chk("j_instr", instr, 32'h4A00_0004);
        chk("j_pre_addr", imem_addr, 32'h1000_0008);

        // Jump: target from pc_plus4 region and instr_index
        jump = 1; jump_index = 26'h000040;
        tick();
        chk("j_addr", imem_addr, 32'h1000_0100);
        chk("j_ifv", {31'b0, if_valid}, {31'b0, DS});
        chk("j_flush", instr, DS ? 32'h4A00_0004 : 32'h0);
        chk("j_pp4_keep", pc_plus4, 32'h1000_0008);
        // Branch and jump together: branch wins
        branch_taken = 1; branch_target = 32'h200;
        tick();
        chk("bj_addr", imem_addr, 32'h200);
        branch_taken = 0; jump = 0; zw = 0;

        // Second instance: RESET_PC = 0xFFFF_FFFC
        chk("w_rst_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("w_rst_req", {31'b0, imem_req2}, 32'h0);
        reset2 = 1; zw2 = 1;
        tick();
        chk("w_f0_req", {31'b0, imem_req2}, 32'h1);
        chk("w_f0_addr", imem_addr2, 32'hFFFF_FFFC);
        tick();
        chk("w_f1_addr", imem_addr2, 32'h0);
        chk("w_f1_pp4", pc_plus42, 32'h0);
        chk("w_f1_instr", instr2, 32'hA5FF_FFFC);
        chk("w_f1_ifv", {31'b0, if_valid2}, 32'h1);

        // Reset during DISCARD; the late reply must be ignored
        zw2 = 0; branch_taken2 = 1; branch_target2 = 32'h40;
        tick();
        branch_taken2 = 0;
        chk("w_dis_req", {31'b0, imem_req2}, 32'h1);
        chk("w_dis_addr", imem_addr2, 32'h0);
        chk("w_dis_ifv", {31'b0, if_valid2}, {31'b0, DS});
        reset2 = 0;
        tick();
        chk("w_rr_req", {31'b0, imem_req2}, 32'h0);
        chk("w_rr_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("w_rr_ifv", {31'b0, if_valid2}, 32'h0);
        chk("w_rr_instr", instr2, 32'h0);
        reset2 = 1; man_valid2 = 1;
        tick();
        chk("w_late_req", {31'b0, imem_req2}, 32'h1);
        chk("w_late_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("w_late_ifv", {31'b0, if_valid2}, 32'h0);
        chk("w_late_instr", instr2, 32'h0);
        man_valid2 = 0;
        tick();
        chk("w_late2_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("w_late2_ifv", {31'b0, if_valid2}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  in  1  synchronous active-low reset; sampled on clk.
REQ-005 SHALL have port stall  in  1  decode-stage hold request; IF/ID and PC frozen.
REQ-006 SHALL have port branch_taken  in  1  resolved taken branch (Branch AND zero).
REQ-007 SHALL have port branch_target  in  32  byte address of taken branch.
REQ-008 SHALL have port jump  in  1  Jump decoded for the instruction in IF/ID.
REQ-009 SHALL have port jump_index  in  26  instr_index field of that jump.
REQ-010 SHALL have port imem_req  out  1  instruction-memory read request.
REQ-011 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-012 SHALL have port imem_rdata  in  32  returned instruction word.
REQ-013 SHALL have port imem_valid  in  1  imem_rdata valid; may assert in the request cycle or any later cycle.
REQ-014 SHALL have port instr  out  32  IF/ID instruction register.
REQ-015 SHALL have port opcode  out  6  instr[31:26], feeds decode control.
REQ-016 SHALL have port pc_plus4  out  32  IF/ID PC+4 of instr.
REQ-017 SHALL have port if_valid  out  1  IF/ID holds a live instruction.

Function
REQ-018 SHALL implement states IDLE, FETCH, HOLD, DISCARD.
REQ-019 IDLE SHALL deassert imem_req and move to FETCH after one cycle.
REQ-020 FETCH SHALL drive imem_req=1 and imem_addr=pc until imem_valid.
REQ-021 On imem_valid with stall=0 and no redirect, it SHALL load instr<=imem_rdata, pc_plus4<=pc+4, if_valid<=1, pc<=pc+4, and stay in FETCH.
REQ-022 On imem_valid with stall=1, it SHALL capture imem_rdata in a holding buffer, leave IF/ID unchanged, and go to HOLD.
REQ-023 HOLD SHALL keep imem_req=0; when stall=0 it SHALL move the buffer to IF/ID, advance pc by 4, and go to FETCH.
REQ-024 Without imem_valid in FETCH, if_valid SHALL clear to 0 (bubble) unless stall=1, which holds IF/ID.
REQ-025 Redirect priority SHALL be branch_taken over jump; the target is branch_target, or {pc_plus4[31:28], jump_index, 2'b00}.
REQ-026 A redirect SHALL take priority over stall: pc<=target, and a held buffer is dropped.
REQ-027 A redirect in FETCH before imem_valid SHALL go to DISCARD, which holds imem_req at the old address until imem_valid, drops that word, then returns to FETCH at the target.
REQ-028 A redirect coincident with imem_valid SHALL drop the returned word and go directly to FETCH at the target.
REQ-029 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-030 Reset SHALL set pc=RESET_PC, instr=32'h0, pc_plus4=32'h0, if_valid=0, imem_req=0, imem_addr=RESET_PC, buffer empty, state IDLE.
REQ-031 Reset mid-operation SHALL abandon any pending request; a later imem_valid SHALL be ignored until FETCH.

Configuration
REQ-032 Macro BRANCH_DELAY_SLOT_EN, when defined, SHALL leave the IF/ID instruction live (if_valid unchanged) on redirect.
REQ-033 Without BRANCH_DELAY_SLOT_EN, a redirect SHALL flush IF/ID: if_valid<=0 and instr<=32'h0.

Structure
REQ-034 Shared package mips_pkg SHALL hold the fetch-state enum typedef, NOP_INSTR=32'h0, PC_INC=4, and the opcode constants.
REQ-035 Sub-module next_pc_sel SHALL hold the combinational next-PC mux: reset/redirect/sequential/hold.

Verification
REQ-036 Reset low 2 cycles, then high, with zero-wait memory: IDLE 1 cycle, then imem_addr 0,4,8 on consecutive cycles; if_valid rises 1 cycle after the first request.
REQ-037 imem_valid delayed 3 cycles on addr 0x10: imem_addr holds 0x10; if_valid=0 for 3 cycles, then instr=rdata and pc_plus4=0x14.
REQ-038 stall=1 for 2 cycles while word 0x8 returns: IF/ID holds 0x4's word; after release instr=word(0x8) and the next address is 0xC.
REQ-039 branch_taken with target 0x100 while the 0x20 request is pending: DISCARD until valid, word dropped, next imem_addr=0x100; with BRANCH_DELAY_SLOT_EN if_valid unchanged, without it if_valid=0.
REQ-040 jump with jump_index=26'h000040, pc_plus4=0x1000_0008: next imem_addr=0x1000_0100; branch_taken in the same cycle wins.
REQ-041 RESET_PC=32'hFFFF_FFFC: first fetch at 0xFFFF_FFFC, second at 0x0; reset asserted during DISCARD returns to IDLE, and the late imem_valid is ignored.
